// File: rtl/blink_rtc.sv
// blink_rtc: prescaled real-time clock with status, interrupt mask, alarm and
// coherent snapshot reads over an 8-bit I/O-port register interface.
//
// Ports:
//   mck      - master clock; all state changes on its rising edge
//   rin_n    - synchronous active-low reset (beats tres and the strobes)
//   tres     - synchronous timer restart; zeroes the counters only
//   wr_stb   - register write strobe (addr/cdi)
//   rd_stb   - register read strobe (addr); rdata valid after the next edge
//   addr     - I/O port address
//   cdi      - write data
//   rdata    - registered read data
//   rtc_int  - interrupt request, |(tsta & tmk)
//   tsta_o   - status bits {alarm, minute, second, tick}
//
// Register map:
//   write B4h : clear tsta bits where cdi[3:0]=1
//   write B5h : tmk <= cdi[3:0]          read B5h : {4'b0, tsta}
//   write D5h..D7h : alarm bytes 0..2    read D0h : tim0, captures snapshot
//                                        read D1h : snap1, D2h..D4h : snapm bytes
module blink_rtc #(
  parameter int unsigned TICK_DIV = 49152,
  parameter int unsigned TIM0_MOD = 200,
  parameter int unsigned TIM1_MOD = 60,
  parameter int unsigned MIN_W    = 21
) (
  input  logic       mck,
  input  logic       rin_n,
  input  logic       tres,
  input  logic       wr_stb,
  input  logic       rd_stb,
  input  logic [7:0] addr,
  input  logic [7:0] cdi,
  output logic [7:0] rdata,
  output logic       rtc_int,
  output logic [3:0] tsta_o
);

  localparam int unsigned TckW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [TckW-1:0] TckLast  = TckW'(TICK_DIV - 1);
  localparam logic [7:0]      Tim0Last = 8'(TIM0_MOD - 1);
  localparam logic [7:0]      Tim1Last = 8'(TIM1_MOD - 1);

  localparam logic [7:0] AddrClr   = 8'hB4;
  localparam logic [7:0] AddrMsk   = 8'hB5;
  localparam logic [7:0] AddrTim0  = 8'hD0;
  localparam logic [7:0] AddrSnap1 = 8'hD1;
  localparam logic [7:0] AddrSnm0  = 8'hD2;
  localparam logic [7:0] AddrSnm1  = 8'hD3;
  localparam logic [7:0] AddrSnm2  = 8'hD4;
  localparam logic [7:0] AddrAlm0  = 8'hD5;
  localparam logic [7:0] AddrAlm1  = 8'hD6;
  localparam logic [7:0] AddrAlm2  = 8'hD7;

  // State
  logic [TckW-1:0]  tck_q, tck_d;
  logic [7:0]       tim0_q, tim0_d;
  logic [7:0]       tim1_q, tim1_d;
  logic [MIN_W-1:0] timm_q, timm_d;
  logic [3:0]       tsta_q, tsta_d;
  logic [3:0]       tmk_q, tmk_d;
  logic [23:0]      alarm_q, alarm_d;
  logic [7:0]       snap1_q, snap1_d;
  logic [MIN_W-1:0] snapm_q, snapm_d;
  logic [7:0]       rdata_q, rdata_d;

  // Events
  logic             tick;
  logic             sec_carry;
  logic             min_carry;
  logic             alarm_hit;
  logic [MIN_W-1:0] timm_inc;
  logic [3:0]       tsta_set;
  logic [3:0]       tsta_clr;
  logic [23:0]      snapm_ext;

  // Alarm bits at or above MIN_W are kept for software but never compared.
  logic unused_alarm;
  assign unused_alarm = ^alarm_q;

  // tres suppresses the tick, and with it every downstream carry.
  assign tick      = (tck_q == TckLast) && !tres;
  assign sec_carry = tick && (tim0_q == Tim0Last);
  assign min_carry = sec_carry && (tim1_q == Tim1Last);
  assign timm_inc  = timm_q + MIN_W'(1);
  assign alarm_hit = min_carry && (timm_inc == alarm_q[MIN_W-1:0]);

  assign tsta_set  = {alarm_hit, min_carry, sec_carry, tick};
  assign tsta_clr  = (wr_stb && (addr == AddrClr)) ? cdi[3:0] : 4'b0000;
  assign snapm_ext = 24'(snapm_q);

  // Counter chain
  always_comb begin
    tck_d  = tck_q;
    tim0_d = tim0_q;
    tim1_d = tim1_q;
    timm_d = timm_q;
    if (tres) begin
      tck_d  = '0;
      tim0_d = '0;
      tim1_d = '0;
      timm_d = '0;
    end else begin
      tck_d = tick ? '0 : tck_q + TckW'(1);
      if (tick) begin
        tim0_d = sec_carry ? 8'd0 : tim0_q + 8'd1;
      end
      if (sec_carry) begin
        tim1_d = min_carry ? 8'd0 : tim1_q + 8'd1;
      end
      if (min_carry) begin
        timm_d = timm_inc;
      end
    end
  end

  // Status, mask, alarm and snapshot registers
  always_comb begin
    // Set wins over a clear hitting the same bit on the same edge.
    tsta_d  = (tsta_q & ~tsta_clr) | tsta_set;
    tmk_d   = tmk_q;
    alarm_d = alarm_q;
    snap1_d = snap1_q;
    snapm_d = snapm_q;
    if (wr_stb) begin
      case (addr)
        AddrMsk:  tmk_d          = cdi[3:0];
        AddrAlm0: alarm_d[7:0]   = cdi;
        AddrAlm1: alarm_d[15:8]  = cdi;
        AddrAlm2: alarm_d[23:16] = cdi;
        default:  ;
      endcase
    end
    if (rd_stb && (addr == AddrTim0)) begin
      snap1_d = tim1_q;
      snapm_d = timm_q;
    end
  end

  // Read mux works from current register values, so a simultaneous write is
  // not visible until the following read.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_stb) begin
      case (addr)
        AddrMsk:   rdata_d = {4'b0000, tsta_q};
        AddrTim0:  rdata_d = tim0_q;
        AddrSnap1: rdata_d = snap1_q;
        AddrSnm0:  rdata_d = snapm_ext[7:0];
        AddrSnm1:  rdata_d = snapm_ext[15:8];
        AddrSnm2:  rdata_d = snapm_ext[23:16];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge mck) begin
    if (!rin_n) begin
      tck_q   <= '0;
      tim0_q  <= '0;
      tim1_q  <= '0;
      timm_q  <= '0;
      tsta_q  <= '0;
      tmk_q   <= '0;
      alarm_q <= '0;
      snap1_q <= '0;
      snapm_q <= '0;
      rdata_q <= '0;
    end else begin
      tck_q   <= tck_d;
      tim0_q  <= tim0_d;
      tim1_q  <= tim1_d;
      timm_q  <= timm_d;
      tsta_q  <= tsta_d;
      tmk_q   <= tmk_d;
      alarm_q <= alarm_d;
      snap1_q <= snap1_d;
      snapm_q <= snapm_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata   = rdata_q;
  assign tsta_o  = tsta_q;
  assign rtc_int = |(tsta_q & tmk_q);

endmodule

// File: tb/tb_blink_rtc.sv
// Self-checking bench for blink_rtc with a small prescaler (TICK_DIV=4,
// TIM0_MOD=3, TIM1_MOD=2, MIN_W=8). With k edges since reset release, a tick
// lands on every k%4==0, a second carry on k%12==0, a minute carry on k%24==0.
// The stimulus pushes expected values into a queue tagged with the edge count
// they apply to; a monitor pops and compares them on the falling edge.
module tb_blink_rtc;

  logic       mck = 1'b0;
  logic       rin_n = 1'b0;
  logic       tres = 1'b0;
  logic       wr_stb = 1'b0;
  logic       rd_stb = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] cdi = 8'h00;
  logic [7:0] rdata;
  logic       rtc_int;
  logic [3:0] tsta_o;

  blink_rtc #(
    .TICK_DIV (4),
    .TIM0_MOD (3),
    .TIM1_MOD (2),
    .MIN_W    (8)
  ) dut (
    .mck     (mck),
    .rin_n   (rin_n),
    .tres    (tres),
    .wr_stb  (wr_stb),
    .rd_stb  (rd_stb),
    .addr    (addr),
    .cdi     (cdi),
    .rdata   (rdata),
    .rtc_int (rtc_int),
    .tsta_o  (tsta_o)
  );

  always #5 mck = ~mck;

  int unsigned cyc = 0;
  always @(posedge mck) cyc <= cyc + 1;

  typedef enum int {SelRdata, SelTsta, SelInt} sel_e;

  typedef struct {
    int unsigned due;
    sel_e        sel;
    logic [7:0]  exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor
  exp_t       mon_e;
  logic [7:0] mon_act;
  always @(negedge mck) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      mon_e = sb_q.pop_front();
      case (mon_e.sel)
        SelRdata: mon_act = rdata;
        SelTsta:  mon_act = {4'b0000, tsta_o};
        default:  mon_act = {7'b0, rtc_int};
      endcase
      checks++;
      if (mon_act !== mon_e.exp) begin
        errors++;
        $display("FAIL %s: got %0h, expected %0h (edge %0d)", mon_e.name, mon_act, mon_e.exp,
                 cyc);
      end
    end
  end

  task automatic push(input sel_e sel, input logic [7:0] v, input string name);
    exp_t e;
    e.due  = cyc;
    e.sel  = sel;
    e.exp  = v;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge mck);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(input logic [7:0] a);
    addr   = a;
    rd_stb = 1'b1;
    step();
    rd_stb = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr   = a;
    cdi    = d;
    wr_stb = 1'b1;
    step();
    wr_stb = 1'b0;
  endtask

  initial begin
    run(2);
    push(SelTsta, 8'h0, "reset_tsta");
    push(SelInt, 8'h0, "reset_int");
    push(SelRdata, 8'h00, "reset_rdata");
    rin_n = 1'b1;                                     // k = 0

    run(3);  push(SelTsta, 8'h0, "no_tick_k3");       // k = 3
    run(1);  push(SelTsta, 8'h1, "first_tick_k4");
    run(7);  push(SelTsta, 8'h1, "tick_only_k11");
    run(1);  push(SelTsta, 8'h3, "sec_carry_k12");
    run(12); push(SelTsta, 8'h7, "min_carry_k24");
             push(SelInt, 8'h0, "int_masked_k24");
    rd(8'hD0); push(SelRdata, 8'h00, "rd_tim0_k24");  // k = 25
    rd(8'hD2); push(SelRdata, 8'h01, "rd_snapm_timm1");

    wr(8'hD5, 8'h02);                                 // k = 27
    wr(8'hB5, 8'h08);                                 // k = 28
    wr(8'hB4, 8'h0F); push(SelTsta, 8'h0, "clear_all");
    run(18); push(SelInt, 8'h0, "no_alarm_k47");
    run(1);  push(SelTsta, 8'hF, "alarm_k48");
             push(SelInt, 8'h1, "alarm_int_k48");
    wr(8'hB4, 8'h08); push(SelTsta, 8'h7, "clear_alarm");
                      push(SelInt, 8'h0, "int_cleared");

    run(2);                                           // k = 51
    wr(8'hB4, 8'h01); push(SelTsta, 8'h7, "set_wins_k52");
    wr(8'hB4, 8'h01); push(SelTsta, 8'h6, "clear_bit0_k53");

    run(12);                                          // k = 65
    rd(8'hD0); push(SelRdata, 8'h01, "rd_tim0_k65");
    run(14);                                          // k = 80, timm now 3
    rd(8'hD2); push(SelRdata, 8'h02, "snapm_coherent");
    rd(8'hD1); push(SelRdata, 8'h01, "snap1_coherent");
    rd(8'hD3); push(SelRdata, 8'h00, "snapm_byte1");
    rd(8'hD0); push(SelRdata, 8'h02, "rd_tim0_k83");
    rd(8'hD2); push(SelRdata, 8'h03, "snapm_updated");
    rd(8'h00); push(SelRdata, 8'h03, "unmapped_rd");
    wr(8'hB6, 8'hFF); push(SelTsta, 8'h7, "unmapped_wr");   // k = 87
                      push(SelInt, 8'h0, "unmapped_wr_int");

    addr = 8'hB5; cdi = 8'h01; wr_stb = 1'b1; rd_stb = 1'b1;
    step();                                           // k = 88
    wr_stb = 1'b0; rd_stb = 1'b0;
    push(SelRdata, 8'h07, "rd_pre_write");
    push(SelInt, 8'h1, "tmk_written");
    wr(8'hB4, 8'h0F); push(SelTsta, 8'h0, "clear_k89");

    run(8);                                           // k = 97
    wr(8'hB4, 8'h0F);                                 // k = 98
    run(10); push(SelTsta, 8'h3, "pre_tres_k108");
    run(3);                                           // k = 111

    tres = 1'b1;
    wr(8'hB5, 8'h02);                                 // edge 112, tick suppressed
    push(SelTsta, 8'h3, "tres_keeps_tsta");
    push(SelInt, 8'h1, "tres_wr_tmk");
    push(SelRdata, 8'h07, "tres_keeps_rdata");
    rd(8'hD0); push(SelRdata, 8'h00, "tres_zero_tim0");     // edge 113
    tres = 1'b0;
    wr(8'hB4, 8'h0F); push(SelTsta, 8'h0, "post_tres_clear");
    rd(8'hD2); push(SelRdata, 8'h00, "tres_zero_timm");
    rd(8'hD1); push(SelRdata, 8'h00, "tres_zero_tim1");
               push(SelTsta, 8'h0, "no_early_tick");
    step();    push(SelTsta, 8'h1, "tick_4_after_tres");
    rd(8'hB5); push(SelRdata, 8'h01, "rd_tsta");

    rin_n = 1'b0; tres = 1'b1; addr = 8'hB5; cdi = 8'h0F; rd_stb = 1'b1; wr_stb = 1'b1;
    step();
    rin_n = 1'b1; tres = 1'b0; rd_stb = 1'b0; wr_stb = 1'b0;
    push(SelRdata, 8'h00, "reset_beats_read");
    push(SelTsta, 8'h0, "reset_tsta_2");
    push(SelInt, 8'h0, "reset_int_2");
    run(3); push(SelTsta, 8'h0, "post_reset_k3");
    run(1); push(SelTsta, 8'h1, "post_reset_tick");
            push(SelInt, 8'h0, "reset_beats_write");

    run(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors += sb_q.size();
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
